projection_frame_sched: RTL and testbench

- Per-axis scheduler for a 1-bit projection RAM (1 = "some marked pixel hit this coordinate").
- Sequences the RAM through clear, one-frame accumulation, edge scan and result publish, and arbitrates the RAM write port between the clear engine and the pixel-marking stream.
- One instance drives the horizontal RAM (i_coord = hcount), a second drives the vertical RAM (i_coord = vcount).
- Sits between the binarisation stage and plate-bound consumers (crop/segment).

---
 rtl/projection_frame_sched_if.sv | 35 +++
 rtl/projection_frame_sched.sv | 194 +++++++++++++++++++
 tb/tb_projection_frame_sched.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/projection_frame_sched_if.sv
// ============================================================================
// Module   : projection_frame_sched_if
// Brief    : Write/read port bundle between the frame scheduler and its
//            1-bit projection RAM.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface projection_frame_sched_if #(
  parameter int ADDR_W = 12
);
  logic              ram_we;
  logic [ADDR_W-1:0] ram_waddr;
  logic              ram_di;
  logic [ADDR_W-1:0] ram_raddr;
  logic              ram_dout;

  modport master (
    output ram_we,
    output ram_waddr,
    output ram_di,
    output ram_raddr,
    input  ram_dout
  );

  modport slave (
    input  ram_we,
    input  ram_waddr,
    input  ram_di,
    input  ram_raddr,
    output ram_dout
  );
endinterface

`default_nettype wire

// File: rtl/projection_frame_sched.sv
// ============================================================================
// Module   : projection_frame_sched
// Brief    : Per-axis projection RAM scheduler: clear, accumulate one frame,
//            scan for the first marked run, publish, re-clear.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module projection_frame_sched #(
  parameter int IMG_WIDTH_LINE = 1024,
  parameter int ADDR_W         = 12,
  parameter int BORDER         = 3
) (
  input  wire logic                  pixelclk,
  input  wire logic                  reset_n,
  input  wire logic                  i_vs,
  input  wire logic                  i_de,
  input  wire logic [11:0]           i_coord,
  input  wire logic                  i_mark,
  projection_frame_sched_if.master   ram,
  output logic      [11:0]           o_lo,
  output logic      [11:0]           o_hi,
  output logic                       o_found,
  output logic                       o_valid,
  output logic                       o_busy,
  output logic                       o_drop
);

  localparam int                  c_cnt_w   = ADDR_W + 1;
  localparam logic [c_cnt_w-1:0]  c_last    = c_cnt_w'(IMG_WIDTH_LINE - 1);
  localparam logic [c_cnt_w-1:0]  c_n       = c_cnt_w'(IMG_WIDTH_LINE);
  localparam logic [12:0]         c_coord_n = 13'(IMG_WIDTH_LINE);
  localparam logic [12:0]         c_border  = 13'(BORDER);

  typedef enum logic [2:0] {
    S_INIT    = 3'd0,
    S_WAIT_VS = 3'd1,
    S_ACCUM   = 3'd2,
    S_SCAN    = 3'd3,
    S_PUBLISH = 3'd4,
    S_CLEAR   = 3'd5
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic                 r_vs;
  logic                 w_vs_fall;
  logic                 w_drop_req;
  logic                 w_clearing;
  logic                 w_mark_ok;
  logic [c_cnt_w-1:0]   r_cnt;
  logic                 r_rd_vld;
  logic [ADDR_W-1:0]    r_raddr_d;
  logic                 r_found;
  logic                 r_done;
  logic [ADDR_W-1:0]    r_lo;
  logic [ADDR_W-1:0]    r_hi;

  assign w_vs_fall  = r_vs & ~i_vs;
  assign w_clearing = (r_state == S_INIT) || (r_state == S_CLEAR);
  // Coordinates at or beyond the RAM depth are rejected, never wrapped.
  assign w_mark_ok  = i_de & i_mark & ({1'b0, i_coord} > c_border)
                    & ({1'b0, i_coord} < c_coord_n);

  always_ff @(posedge pixelclk or negedge reset_n) begin
    if (!reset_n) r_state <= S_INIT;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    o_busy      = 1'b0;
    w_drop_req  = 1'b0;
    case (r_state)
      S_INIT, S_CLEAR: begin
        o_busy     = 1'b1;
        w_drop_req = w_vs_fall;
        if (r_cnt == c_last) w_state_nxt = S_WAIT_VS;
      end
      S_WAIT_VS: begin
        if (w_vs_fall) w_state_nxt = S_ACCUM;
      end
      S_ACCUM: begin
        if (w_vs_fall) w_state_nxt = S_SCAN;
      end
      S_SCAN: begin
        o_busy     = 1'b1;
        w_drop_req = w_vs_fall;
        if (r_cnt == c_n) w_state_nxt = S_PUBLISH;
      end
      S_PUBLISH: begin
        o_busy      = 1'b1;
        w_drop_req  = w_vs_fall;
        w_state_nxt = S_CLEAR;
      end
      default: begin
        o_busy      = 1'b1;
        w_state_nxt = S_INIT;
      end
    endcase
  end

  // Shared sequencing counter: clear address in INIT/CLEAR, cycle index in SCAN.
  always_ff @(posedge pixelclk or negedge reset_n) begin
    if (!reset_n) begin
      r_vs  <= 1'b0;
      r_cnt <= '0;
    end else begin
      r_vs <= i_vs;
      if (w_state_nxt != r_state)
        r_cnt <= '0;
      else if (w_clearing || (r_state == S_SCAN))
        r_cnt <= r_cnt + c_cnt_w'(1);
    end
  end

  always_ff @(posedge pixelclk or negedge reset_n) begin
    if (!reset_n) begin
      ram.ram_we    <= 1'b0;
      ram.ram_waddr <= '0;
      ram.ram_di    <= 1'b0;
    end else if (w_clearing) begin
      ram.ram_we    <= 1'b1;
      ram.ram_waddr <= r_cnt[ADDR_W-1:0];
      ram.ram_di    <= 1'b0;
    end else if (r_state == S_ACCUM) begin
      ram.ram_we    <= w_mark_ok;
      ram.ram_waddr <= ADDR_W'(i_coord);
      ram.ram_di    <= w_mark_ok;
    end else begin
      ram.ram_we    <= 1'b0;
      ram.ram_di    <= 1'b0;
    end
  end

  // Read side: address walks 0..N-1, data is judged one cycle later against r_raddr_d.
  always_ff @(posedge pixelclk or negedge reset_n) begin
    if (!reset_n) begin
      ram.ram_raddr <= '0;
      r_raddr_d     <= '0;
      r_rd_vld      <= 1'b0;
      r_found       <= 1'b0;
      r_done        <= 1'b0;
      r_lo          <= '0;
      r_hi          <= '0;
    end else begin
      r_raddr_d <= ram.ram_raddr;
      r_rd_vld  <= (r_state == S_SCAN) && (r_cnt < c_n);
      if (r_state == S_SCAN) begin
        if (r_cnt < c_last) ram.ram_raddr <= ram.ram_raddr + ADDR_W'(1);
      end else begin
        ram.ram_raddr <= '0;
      end

      if (r_state == S_ACCUM) begin
        r_found <= 1'b0;
        r_done  <= 1'b0;
        r_lo    <= '0;
        r_hi    <= '0;
      end else if ((r_state == S_SCAN) && r_rd_vld && !r_done) begin
        if (ram.ram_dout) begin
          if (!r_found) begin
            r_found <= 1'b1;
            r_lo    <= r_raddr_d;
          end
          r_hi <= r_raddr_d;
        end else if (r_found) begin
          r_done <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge pixelclk or negedge reset_n) begin
    if (!reset_n) begin
      o_lo    <= '0;
      o_hi    <= '0;
      o_found <= 1'b0;
      o_valid <= 1'b0;
      o_drop  <= 1'b0;
    end else begin
      o_valid <= (r_state == S_PUBLISH);
      o_drop  <= w_drop_req;
      if (r_state == S_PUBLISH) begin
        o_found <= r_found;
        o_lo    <= r_found ? 12'(r_lo) : 12'd0;
        o_hi    <= r_found ? 12'(r_hi) : 12'd0;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_projection_frame_sched.sv
// ============================================================================
// Module   : tb_projection_frame_sched
// Brief    : Directed frames against projection_frame_sched with a RAM model
//            and an expected-result queue popped on o_valid.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_projection_frame_sched;

  localparam int N = 64;

  logic        pixelclk = 1'b0;
  logic        reset_n  = 1'b0;
  logic        i_vs     = 1'b0;
  logic        i_de     = 1'b0;
  logic [11:0] i_coord  = '0;
  logic        i_mark   = 1'b0;
  logic [11:0] o_lo, o_hi;
  logic        o_found, o_valid, o_busy, o_drop;

  projection_frame_sched_if #(.ADDR_W(12)) ram_if ();

  projection_frame_sched #(
    .IMG_WIDTH_LINE(N),
    .ADDR_W        (12),
    .BORDER        (3)
  ) dut (
    .pixelclk(pixelclk),
    .reset_n (reset_n),
    .i_vs    (i_vs),
    .i_de    (i_de),
    .i_coord (i_coord),
    .i_mark  (i_mark),
    .ram     (ram_if),
    .o_lo    (o_lo),
    .o_hi    (o_hi),
    .o_found (o_found),
    .o_valid (o_valid),
    .o_busy  (o_busy),
    .o_drop  (o_drop)
  );

  always #5 pixelclk = ~pixelclk;

  // RAM starts full of ones so a missing clear corrupts the results.
  bit mem [0:4095] = '{default: 1'b1};
  always @(posedge pixelclk) begin
    if (ram_if.ram_we) mem[ram_if.ram_waddr] <= ram_if.ram_di;
    ram_if.ram_dout <= mem[ram_if.ram_raddr];
  end

  typedef struct {
    int lo;
    int hi;
    int found;
    int fc;
  } exp_t;

  exp_t         q[$];
  int           n_checks = 0;
  int           n_fail   = 0;
  int           cyc      = 0;
  int           drop_seen = 0;
  int           drop_exp  = 0;
  logic [127:0] cur_mask = '0;
  logic         wr_ok;

  always @(posedge pixelclk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [127:0] rng(input int a, input int b);
    logic [127:0] m;
    m = '0;
    for (int k = a; k <= b; k++) m[k] = 1'b1;
    return m;
  endfunction

  // Scoreboard monitor: every result pulse must match the oldest expected entry.
  always @(negedge pixelclk) begin
    if (reset_n && o_valid) begin
      if (q.size() == 0) begin
        chk("unexpected_valid", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("result_lo", 32'(o_lo), e.lo);
        chk("result_hi", 32'(o_hi), e.hi);
        chk("result_found", 32'(o_found), e.found);
        chk("result_latency", cyc - e.fc, 67);
      end
    end
  end

  always @(negedge pixelclk) begin
    if (reset_n && o_drop) drop_seen++;
  end

  // Every set-bit write must target a legal, in-range marked coordinate.
  always @(negedge pixelclk) begin
    if (reset_n && ram_if.ram_we && ram_if.ram_di) begin
      wr_ok = (ram_if.ram_waddr < 12'd64) && (ram_if.ram_waddr > 12'd3)
            && cur_mask[ram_if.ram_waddr[6:0]];
      chk($sformatf("mark_write_addr_%0d", ram_if.ram_waddr), 32'(wr_ok), 32'd1);
    end
  end

  task automatic tick();
    @(posedge pixelclk);
    #1;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while (o_busy && t < 1000) begin
      tick();
      t++;
    end
    chk("wait_idle_timeout", 32'(o_busy), 32'd0);
  endtask

  task automatic vs_pulse(output int fall_cyc);
    i_vs = 1'b1;
    tick();
    tick();
    i_vs = 1'b0;
    fall_cyc = cyc;
    tick();
  endtask

  task automatic send_pixels(input logic [127:0] m);
    for (int c = 0; c < 128; c++) begin
      i_de    = 1'b1;
      i_coord = 12'(c);
      i_mark  = m[c];
      tick();
    end
    i_de   = 1'b0;
    i_mark = 1'b0;
  endtask

  task automatic accumulate(input logic [127:0] m, output int fc);
    int d;
    wait_idle();
    cur_mask = m;
    vs_pulse(d);
    send_pixels(m);
    vs_pulse(fc);
  endtask

  task automatic run_frame(input logic [127:0] m, input int lo, input int hi, input int found);
    int fc;
    exp_t e;
    accumulate(m, fc);
    e.lo = lo; e.hi = hi; e.found = found; e.fc = fc;
    q.push_back(e);
  endtask

  task automatic check_clear();
    int w;
    w = 0;
    @(negedge pixelclk);
    while (!ram_if.ram_we && w < 10) begin
      @(negedge pixelclk);
      w++;
    end
    for (int i = 0; i < N; i++) begin
      chk("clear_we", 32'(ram_if.ram_we), 32'd1);
      chk("clear_addr", 32'(ram_if.ram_waddr), 32'(i));
      chk("clear_di", 32'(ram_if.ram_di), 32'd0);
      @(negedge pixelclk);
    end
    chk("clear_end_we", 32'(ram_if.ram_we), 32'd0);
    chk("clear_end_busy", 32'(o_busy), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int fc;
    int d;
    tick();
    tick();
    chk("reset_we", 32'(ram_if.ram_we), 32'd0);
    chk("reset_lo", 32'(o_lo), 32'd0);
    chk("reset_found", 32'(o_found), 32'd0);
    chk("reset_valid", 32'(o_valid), 32'd0);
    chk("reset_busy", 32'(o_busy), 32'd1);
    reset_n = 1'b1;
    check_clear();
    tick();

    run_frame(rng(10, 20), 10, 20, 1);
    wait_idle();
    chk("hold_lo", 32'(o_lo), 32'd10);
    chk("hold_hi", 32'(o_hi), 32'd20);

    run_frame(rng(2, 3) | rng(30, 31) | rng(40, 45), 30, 31, 1);
    run_frame(rng(60, 63) | rng(70, 70), 60, 63, 1);

    run_frame('0, 0, 0, 0);
    repeat (5) tick();
    vs_pulse(d);
    drop_exp++;

    run_frame(rng(15, 16) | rng(50, 50), 15, 16, 1);

    accumulate(rng(33, 33), fc);
    repeat (10) tick();
    @(negedge pixelclk);
    reset_n = 1'b0;
    #1;
    chk("midreset_lo", 32'(o_lo), 32'd0);
    chk("midreset_hi", 32'(o_hi), 32'd0);
    chk("midreset_found", 32'(o_found), 32'd0);
    chk("midreset_busy", 32'(o_busy), 32'd1);
    tick();
    tick();
    reset_n = 1'b1;
    check_clear();
    chk("post_reset_lo", 32'(o_lo), 32'd0);
    tick();

    run_frame(rng(5, 5), 5, 5, 1);
    wait_idle();
    repeat (5) tick();

    chk("queue_empty", 32'(q.size()), 32'd0);
    chk("drop_count", 32'(drop_seen), 32'(drop_exp));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
